mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared memory data port: CPU load/store path vs DMA bulk loader.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [2:0]          cpu_storecntrl,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_hold,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dma_req,
  input  logic                dma_lock,
  input  logic [DATA_W/8-1:0] dma_wen,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [2:0]          mem_storecntrl,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]         cpu_stall_cnt,
  output logic [15:0]         dma_starve_cnt
`endif
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_PRI, ST_LOCK} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_rd_pend;
  logic              r_rd_owner_dma;

  logic w_wait_full;
  logic w_lock_full;
  logic w_dma_gnt;
  logic w_cpu_gnt;
  logic w_rd_grant;

  assign w_wait_full = (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_lock_full = (r_lock_cnt == LOCK_W'(LOCK_MAX));

  // DMA wins when the CPU is idle, when it has starved, or while a burst lock is still within budget
  assign w_dma_gnt = dma_req & (~cpu_req | w_wait_full |
                                ((r_state == ST_LOCK) & ~w_lock_full));
  assign w_cpu_gnt = cpu_req & ~w_dma_gnt;

  assign dma_gnt  = w_dma_gnt;
  assign cpu_hold = cpu_req & ~w_cpu_gnt;
  assign mem_en   = w_cpu_gnt | w_dma_gnt;

  always_comb begin
    mem_wen        = '0;
    mem_storecntrl = 3'b000;
    mem_addr       = '0;
    mem_din        = '0;
    if (w_dma_gnt) begin
      mem_wen  = dma_wen;
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
    end else if (w_cpu_gnt) begin
      mem_wen        = cpu_wen;
      mem_storecntrl = cpu_storecntrl;
      mem_addr       = cpu_addr;
      mem_din        = cpu_wdata;
    end
  end

  assign w_rd_grant = mem_en & (mem_wen == BE_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_PRI;
      r_wait_cnt     <= '0;
      r_lock_cnt     <= '0;
      r_rd_pend      <= 1'b0;
      r_rd_owner_dma <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_owner_dma <= w_dma_gnt;
      end

      if (!dma_req || w_dma_gnt) begin
        r_wait_cnt <= '0;
      end else if (!w_wait_full) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      case (r_state)
        ST_PRI: begin
          if (w_dma_gnt && dma_lock) begin
            r_state    <= ST_LOCK;
            r_lock_cnt <= LOCK_W'(1);
          end
        end
        ST_LOCK: begin
          if (!dma_req || (w_dma_gnt && !dma_lock)) begin
            r_state    <= ST_PRI;
            r_lock_cnt <= '0;
          end else if (w_dma_gnt) begin
            // A full lock only grants again when the CPU is idle (restart at 1) or the DMA starved (stay saturated)
            if (w_lock_full) begin
              r_lock_cnt <= cpu_req ? r_lock_cnt : LOCK_W'(1);
            end else begin
              r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            end
          end else if (w_cpu_gnt && w_lock_full) begin
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_PRI;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  assign cpu_rvalid = r_rd_pend & ~r_rd_owner_dma;
  assign dma_rvalid = r_rd_pend &  r_rd_owner_dma;
  assign cpu_rdata  = mem_dout;
  assign dma_rdata  = mem_dout;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stall_cnt  <= '0;
      dma_starve_cnt <= '0;
    end else begin
      if (cpu_hold && (cpu_stall_cnt != 16'hFFFF)) begin
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
      if (w_wait_full && (dma_starve_cnt != 16'hFFFF)) begin
        dma_starve_cnt <= dma_starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration and read-return rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [2:0]  cpu_storecntrl;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic        dma_lock;
  logic [3:0]  dma_wen;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [2:0]  mem_storecntrl;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
  logic [15:0] dma_starve_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_storecntrl(cpu_storecntrl),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_wen(dma_wen),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_storecntrl(mem_storecntrl),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt), .dma_starve_cnt(dma_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: 16 words, synchronous read, byte-enabled write
  logic [31:0] envMem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'h0) begin
        mem_dout <= envMem[mem_addr[5:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wen[b]) envMem[mem_addr[5:2]][8*b +: 8] <= mem_din[8*b +: 8];
        end
      end
    end
  end

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [31:0] refMem [16];
  int  refused;
  bit  inBurst;
  int  burstGrants;
  bit  expPend;
  bit  expOwnerDma;
  logic [31:0] expData;

  // Values observed from the DUT in the most recent cycle, for directed checks
  bit obsHold, obsEn, obsDmaGnt, obsCpuRv, obsDmaRv;
  bit modelCpuHeld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    refused     = 0;
    inBurst     = 0;
    burstGrants = 0;
    expPend     = 0;
    expOwnerDma = 0;
    expData     = '0;
    modelCpuHeld = 0;
  endtask

  task automatic idleInputs();
    cpu_req = 0; cpu_wen = 0; cpu_storecntrl = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_lock = 0; dma_wen = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge
  task automatic runCycle();
    bit dWin, cWin, cReq, dReq, dLock;
    logic [3:0]  wen;
    logic [31:0] addr, din;
    @(negedge clk);
    cReq  = cpu_req;
    dReq  = dma_req;
    dLock = dma_lock;
    dWin  = dReq && (!cReq || refused >= MAX_WAIT || (inBurst && burstGrants < LOCK_MAX));
    cWin  = cReq && !dWin;
    wen   = dWin ? dma_wen   : (cWin ? cpu_wen   : 4'h0);
    addr  = dWin ? dma_addr  : (cWin ? cpu_addr  : 32'h0);
    din   = dWin ? dma_wdata : (cWin ? cpu_wdata : 32'h0);

    check("dma_gnt",  dma_gnt,  dWin);
    check("cpu_hold", cpu_hold, cReq && !cWin);
    check("mem_en",   mem_en,   dWin || cWin);
    check("mem_addr", mem_addr, addr);
    check("mem_wen_din", {mem_wen, mem_din}, {wen, din});
    check("mem_storecntrl", mem_storecntrl, cWin ? cpu_storecntrl : 3'b000);
    check("rvalid_pair", {cpu_rvalid, dma_rvalid}, {expPend && !expOwnerDma, expPend && expOwnerDma});
    if (expPend) begin
      check("rdata", expOwnerDma ? dma_rdata : cpu_rdata, expData);
    end
    obsHold   = cpu_hold;
    obsEn     = mem_en;
    obsDmaGnt = dma_gnt;
    obsCpuRv  = cpu_rvalid;
    obsDmaRv  = dma_rvalid;
    modelCpuHeld = cReq && !cWin;

    @(posedge clk);
    expPend = (dWin || cWin) && (wen == 4'h0);
    if (expPend) begin
      expOwnerDma = dWin;
      expData     = refMem[addr[5:2]];
    end
    if (dWin || cWin) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) refMem[addr[5:2]][8*b +: 8] = din[8*b +: 8];
      end
    end
    refused = (dReq && !dWin) ? ((refused + 1 > MAX_WAIT) ? MAX_WAIT : refused + 1) : 0;
    if (!inBurst) begin
      if (dWin && dLock) begin
        inBurst = 1;
        burstGrants = 1;
      end
    end else if (!dReq || (dWin && !dLock)) begin
      inBurst = 0;
      burstGrants = 0;
    end else if (dWin) begin
      if (burstGrants == LOCK_MAX) burstGrants = cReq ? LOCK_MAX : 1;
      else burstGrants = burstGrants + 1;
    end else if (cWin && burstGrants == LOCK_MAX) begin
      burstGrants = 0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      envMem[i] = 32'hA5000000 + 32'(i * 32'h01010101);
      refMem[i] = envMem[i];
    end
    mem_dout = '0;
    idleInputs();
    resetModel();
    rst_n = 0;
    #2;
    check("reset_outputs", {cpu_hold, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_wen, mem_addr, mem_din},
          '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Test 1: lone CPU read
    cpu_req = 1; cpu_addr = 32'h0001_0010; cpu_wen = 4'h0; cpu_storecntrl = 3'b010;
    runCycle();
    check("t1_hold", obsHold, 0);
    check("t1_en", obsEn, 1);
    idleInputs();
    runCycle();
    check("t1_rvalid", obsCpuRv, 1);

    // Test 2: both requesting, DMA unlocked: 4 CPU grants then 1 DMA grant, repeating
    cpu_req = 1; cpu_addr = 32'h0000_0020; cpu_wen = 4'h3; cpu_wdata = 32'h1234_5678;
    dma_req = 1; dma_lock = 0; dma_addr = 32'h0000_0024; dma_wen = 4'h0;
    for (int k = 0; k < 10; k++) begin
      runCycle();
      check("t2_hold", obsHold, (k % 5) == 4);
    end
    idleInputs();
    runCycle();

    // Test 3: 3-word locked DMA burst, CPU arrives mid-burst
    dma_req = 1; dma_lock = 1; dma_wen = 4'hF; dma_addr = 32'h0000_0030; dma_wdata = 32'hDEAD_0001;
    runCycle();
    cpu_req = 1; cpu_wen = 4'h0; cpu_addr = 32'h0000_0004;
    dma_addr = 32'h0000_0034; dma_wdata = 32'hDEAD_0002;
    runCycle();
    check("t3_hold_b", obsHold, 1);
    dma_lock = 0; dma_addr = 32'h0000_0038; dma_wdata = 32'hDEAD_0003;
    runCycle();
    check("t3_hold_c", {obsHold, obsDmaGnt}, 2'b11);
    dma_req = 0; dma_wen = 0;
    runCycle();
    check("t3_cpu_gnt", {obsHold, obsEn}, 2'b01);
    idleInputs();
    runCycle();

    // Test 4: lock held with CPU requesting: 16 DMA grants, 1 CPU slot, DMA resumes
    dma_req = 1; dma_lock = 1; dma_wen = 4'h0; dma_addr = 32'h0000_0008;
    for (int k = 0; k < 36; k++) begin
      if (k == 1) begin
        cpu_req = 1; cpu_wen = 4'h0; cpu_addr = 32'h0000_000C;
      end
      runCycle();
      check("t4_dma_gnt", obsDmaGnt, (k != 16) && (k != 33));
    end
    idleInputs();
    runCycle();

    // Test 5: CPU read, DMA read, DMA write on consecutive cycles
    cpu_req = 1; cpu_wen = 4'h0; cpu_addr = 32'h0000_0014;
    runCycle();
    idleInputs();
    dma_req = 1; dma_wen = 4'h0; dma_addr = 32'h0000_0018;
    runCycle();
    check("t5_rv_b", {obsCpuRv, obsDmaRv}, 2'b10);
    dma_wen = 4'hF; dma_wdata = 32'hCAFE_F00D; dma_addr = 32'h0000_0018;
    runCycle();
    check("t5_rv_c", {obsCpuRv, obsDmaRv}, 2'b01);
    idleInputs();
    runCycle();
    check("t5_rv_d", {obsCpuRv, obsDmaRv}, 2'b00);

    // Test 6: asynchronous reset with a read in flight
    cpu_req = 1; cpu_wen = 4'h0; cpu_addr = 32'h0000_001C;
    runCycle();
    idleInputs();
    rst_n = 0;
    #1;
    check("t6_async_reset", {cpu_rvalid, dma_rvalid, mem_en, dma_gnt, cpu_hold, mem_addr}, '0);
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_in_reset", {cpu_rvalid, dma_rvalid}, 2'b00);
    rst_n = 1;
    @(posedge clk);
    #1;
    runCycle();

    // Random traffic; the CPU keeps its request stable while held
    for (int n = 0; n < 400; n++) begin
      if (!modelCpuHeld) begin
        cpu_req        = ($urandom_range(0, 2) != 0);
        cpu_wen        = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
        cpu_storecntrl = 3'($urandom);
        cpu_addr       = $urandom & 32'hFFFF_FFFC;
        cpu_wdata      = $urandom;
      end
      dma_req   = ($urandom_range(0, 1) != 0);
      dma_lock  = dma_req && ($urandom_range(0, 9) < 7);
      dma_wen   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
      dma_addr  = $urandom & 32'hFFFF_FFFC;
      dma_wdata = $urandom;
      runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
